// File: rtl/ife_block_dispatcher_if.sv
// Bundle of the block-queue input, the per-instruction issue stream and the completion record
// of the IFE block dispatcher.
interface ife_block_dispatcher_if #(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int INSTR_WIDTH    = 32,
    parameter int BLOCK_SIZE     = 4
);
    localparam int SLOT_W = $clog2(BLOCK_SIZE);
    localparam int CNT_W  = $clog2(BLOCK_SIZE + 1);

    logic                              flush;
    logic [BLOCK_ID_WIDTH-1:0]         block_id_in;
    logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_in;
    logic                              block_valid;
    logic                              block_ready;
    logic [INSTR_WIDTH-1:0]            instr_out;
    logic [BLOCK_ID_WIDTH-1:0]         instr_block_id;
    logic [SLOT_W-1:0]                 instr_slot;
    logic                              instr_last;
    logic                              instr_valid;
    logic                              instr_ready;
    logic                              done_valid;
    logic [BLOCK_ID_WIDTH-1:0]         done_block_id;
    logic [CNT_W-1:0]                  done_count;

    // The dispatcher side drives the issue stream and completion record.
    modport master (
        input  flush, block_id_in, block_in, block_valid, instr_ready,
        output block_ready, instr_out, instr_block_id, instr_slot, instr_last, instr_valid,
               done_valid, done_block_id, done_count
    );

    modport slave (
        output flush, block_id_in, block_in, block_valid, instr_ready,
        input  block_ready, instr_out, instr_block_id, instr_slot, instr_last, instr_valid,
               done_valid, done_block_id, done_count
    );
endinterface

// File: rtl/ife_block_dispatcher.sv
// Serialises queued instruction blocks into a tagged one-instruction-per-handshake issue stream,
// optionally dropping NOP slots, and reports a completion record per block.
module ife_block_dispatcher #(
    parameter int                     BLOCK_ID_WIDTH = 8,
    parameter int                     INSTR_WIDTH    = 32,
    parameter int                     BLOCK_SIZE     = 4,
    parameter int                     SKIP_NOPS      = 1,
    parameter logic [INSTR_WIDTH-1:0] NOP_ENC        = INSTR_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    ife_block_dispatcher_if.master bus
);
    localparam int SLOT_W = $clog2(BLOCK_SIZE);
    localparam int CNT_W  = $clog2(BLOCK_SIZE + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                            state, state_next;
    logic [BLOCK_ID_WIDTH-1:0]         held_id;
    logic [BLOCK_SIZE*INSTR_WIDTH-1:0] held_words;
    logic [BLOCK_SIZE-1:0]             rem;
    logic [BLOCK_SIZE-1:0]             cap_mask;
    logic [CNT_W-1:0]                  issued;
    logic [SLOT_W-1:0]                 slot;
    logic                              last;
    logic                              issuing;
    logic                              fire;
    logic                              accept;
    logic                              pend_valid;
    logic [BLOCK_ID_WIDTH-1:0]         pend_id;

    always_comb begin
        cap_mask = '1;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if ((SKIP_NOPS != 0) && (bus.block_in[i*INSTR_WIDTH +: INSTR_WIDTH] == NOP_ENC)) begin
                cap_mask[i] = 1'b0;
            end
        end
    end

    // Lowest remaining slot is issued next, so slots always leave in ascending order.
    always_comb begin
        slot = '0;
        for (int i = BLOCK_SIZE - 1; i >= 0; i--) begin
            if (rem[i]) begin
                slot = SLOT_W'(i);
            end
        end
        last = ($countones(rem) == 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next         = state;
        issuing            = (state == ISSUE);
        fire               = issuing && bus.instr_ready;
        bus.block_ready    = !bus.flush && (!issuing || (fire && last));
        accept             = bus.block_valid && bus.block_ready;
        bus.instr_valid    = issuing;
        bus.instr_out      = '0;
        bus.instr_block_id = '0;
        bus.instr_slot     = '0;
        bus.instr_last     = 1'b0;
        if (issuing) begin
            bus.instr_out      = held_words[slot*INSTR_WIDTH +: INSTR_WIDTH];
            bus.instr_block_id = held_id;
            bus.instr_slot     = slot;
            bus.instr_last     = last;
        end
        if (bus.flush) begin
            state_next = IDLE;
        end else if (accept) begin
            state_next = (cap_mask != '0) ? ISSUE : IDLE;
        end else if (fire && last) begin
            state_next = IDLE;
        end
    end

    // An all-skipped block accepted while another completion is being reported in the same
    // cycle is parked in pend_* and reported one cycle later, so no completion is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_id           <= '0;
            held_words        <= '0;
            rem               <= '0;
            issued            <= '0;
            pend_valid        <= 1'b0;
            pend_id           <= '0;
            bus.done_valid    <= 1'b0;
            bus.done_block_id <= '0;
            bus.done_count    <= '0;
        end else begin
            bus.done_valid <= 1'b0;
            pend_valid     <= 1'b0;
            if (pend_valid) begin
                bus.done_valid    <= 1'b1;
                bus.done_block_id <= pend_id;
                bus.done_count    <= '0;
            end
            if (bus.flush) begin
                rem    <= '0;
                issued <= '0;
            end else begin
                if (fire) begin
                    rem[slot] <= 1'b0;
                    issued    <= issued + CNT_W'(1);
                    if (last) begin
                        bus.done_valid    <= 1'b1;
                        bus.done_block_id <= held_id;
                        bus.done_count    <= issued + CNT_W'(1);
                    end
                end
                if (accept) begin
                    held_id    <= bus.block_id_in;
                    held_words <= bus.block_in;
                    rem        <= cap_mask;
                    issued     <= '0;
                    if (cap_mask == '0) begin
                        if (fire || pend_valid) begin
                            pend_valid <= 1'b1;
                            pend_id    <= bus.block_id_in;
                        end else begin
                            bus.done_valid    <= 1'b1;
                            bus.done_block_id <= bus.block_id_in;
                            bus.done_count    <= '0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ife_block_dispatcher.sv
// Table-driven bench for ife_block_dispatcher: one vector per clock cycle, plus hand-written
// sequences for reset, asynchronous reset mid-block and the no-skip configuration.
module tb_ife_block_dispatcher;
    localparam logic [127:0] BA = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] BC = {32'h88, 32'h77, 32'h66, 32'h55};
    localparam logic [127:0] BN = {32'hB0, 32'h13, 32'hA0, 32'h13};
    localparam logic [127:0] BZ = {4{32'h13}};

    typedef struct {
        logic         flush;
        logic         bv;
        logic [7:0]   bid;
        logic [127:0] blk;
        logic         ir;
        logic         e_iv;
        logic [31:0]  e_out;
        logic [7:0]   e_iid;
        logic [1:0]   e_slot;
        logic         e_last;
        logic         e_br;
        logic         e_dv;
        logic [7:0]   e_did;
        logic [2:0]   e_dcnt;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    vec_t   vecs[$];
    int     n_checks = 0;
    int     n_fail = 0;

    always #5 clk = ~clk;

    ife_block_dispatcher_if #(.BLOCK_ID_WIDTH(8), .INSTR_WIDTH(32), .BLOCK_SIZE(4)) bus ();
    ife_block_dispatcher_if #(.BLOCK_ID_WIDTH(8), .INSTR_WIDTH(32), .BLOCK_SIZE(4)) busn ();

    ife_block_dispatcher #(
        .BLOCK_ID_WIDTH(8), .INSTR_WIDTH(32), .BLOCK_SIZE(4), .SKIP_NOPS(1), .NOP_ENC(32'h13)
    ) dut (.clk(clk), .rst(rst), .bus(bus.master));

    ife_block_dispatcher #(
        .BLOCK_ID_WIDTH(8), .INSTR_WIDTH(32), .BLOCK_SIZE(4), .SKIP_NOPS(0), .NOP_ENC(32'h13)
    ) dutn (.clk(clk), .rst(rst), .bus(busn.master));

    function automatic vec_t mk(input logic f, input logic bv, input logic [7:0] bid,
                                input logic [127:0] blk, input logic ir, input logic iv,
                                input logic [31:0] out, input logic [7:0] iid, input logic [1:0] sl,
                                input logic ls, input logic br, input logic dv,
                                input logic [7:0] did, input logic [2:0] dcnt);
        vec_t v;
        v.flush = f;   v.bv = bv;       v.bid = bid;    v.blk = blk;     v.ir = ir;
        v.e_iv = iv;   v.e_out = out;   v.e_iid = iid;  v.e_slot = sl;   v.e_last = ls;
        v.e_br = br;   v.e_dv = dv;     v.e_did = did;  v.e_dcnt = dcnt;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.flush       = v.flush;
        bus.block_valid = v.bv;
        bus.block_id_in = v.bid;
        bus.block_in    = v.blk;
        bus.instr_ready = v.ir;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] blkn;
        bus.flush = 1'b0;  bus.block_valid = 1'b0;  bus.block_id_in = '0;
        bus.block_in = '0; bus.instr_ready = 1'b1;
        busn.flush = 1'b0; busn.block_valid = 1'b0; busn.block_id_in = '0;
        busn.block_in = '0; busn.instr_ready = 1'b1;

        //           f bv bid    blk ir iv out     iid    sl ls br dv did    cnt
        vecs.push_back(mk(0,1,8'h05,BA,1, 0,32'h00,8'h00,0,0, 1, 0,8'h00,0));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h11,8'h05,0,0, 0, 0,8'h00,0));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h22,8'h05,1,0, 0, 0,8'h00,0));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h33,8'h05,2,0, 0, 0,8'h00,0));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h44,8'h05,3,1, 1, 0,8'h00,0));
        vecs.push_back(mk(0,0,8'h00,0, 1, 0,32'h00,8'h00,0,0, 1, 1,8'h05,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 0,32'h00,8'h00,0,0, 1, 0,8'h05,4));
        vecs.push_back(mk(0,1,8'h10,BN,1, 0,32'h00,8'h00,0,0, 1, 0,8'h05,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'hA0,8'h10,1,0, 0, 0,8'h05,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'hB0,8'h10,3,1, 1, 0,8'h05,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 0,32'h00,8'h00,0,0, 1, 1,8'h10,2));
        vecs.push_back(mk(0,1,8'h07,BZ,1, 0,32'h00,8'h00,0,0, 1, 0,8'h10,2));
        vecs.push_back(mk(0,0,8'h00,0, 1, 0,32'h00,8'h00,0,0, 1, 1,8'h07,0));
        vecs.push_back(mk(0,1,8'h01,BA,1, 0,32'h00,8'h00,0,0, 1, 0,8'h07,0));
        vecs.push_back(mk(0,1,8'h02,BC,1, 1,32'h11,8'h01,0,0, 0, 0,8'h07,0));
        vecs.push_back(mk(0,1,8'h02,BC,1, 1,32'h22,8'h01,1,0, 0, 0,8'h07,0));
        vecs.push_back(mk(0,1,8'h02,BC,1, 1,32'h33,8'h01,2,0, 0, 0,8'h07,0));
        vecs.push_back(mk(0,1,8'h02,BC,1, 1,32'h44,8'h01,3,1, 1, 0,8'h07,0));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h55,8'h02,0,0, 0, 1,8'h01,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h66,8'h02,1,0, 0, 0,8'h01,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h77,8'h02,2,0, 0, 0,8'h01,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h88,8'h02,3,1, 1, 0,8'h01,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 0,32'h00,8'h00,0,0, 1, 1,8'h02,4));
        vecs.push_back(mk(0,1,8'h20,BA,1, 0,32'h00,8'h00,0,0, 1, 0,8'h02,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h11,8'h20,0,0, 0, 0,8'h02,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h22,8'h20,1,0, 0, 0,8'h02,4));
        vecs.push_back(mk(0,0,8'h00,0, 0, 1,32'h33,8'h20,2,0, 0, 0,8'h02,4));
        vecs.push_back(mk(0,0,8'h00,0, 0, 1,32'h33,8'h20,2,0, 0, 0,8'h02,4));
        vecs.push_back(mk(0,0,8'h00,0, 0, 1,32'h33,8'h20,2,0, 0, 0,8'h02,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h33,8'h20,2,0, 0, 0,8'h02,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h44,8'h20,3,1, 1, 0,8'h02,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 0,32'h00,8'h00,0,0, 1, 1,8'h20,4));
        vecs.push_back(mk(0,1,8'h30,BA,1, 0,32'h00,8'h00,0,0, 1, 0,8'h20,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h11,8'h30,0,0, 0, 0,8'h20,4));
        vecs.push_back(mk(1,1,8'h31,BC,1, 1,32'h22,8'h30,1,0, 0, 0,8'h20,4));
        vecs.push_back(mk(0,1,8'h31,BC,1, 0,32'h00,8'h00,0,0, 1, 0,8'h20,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h55,8'h31,0,0, 0, 0,8'h20,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h66,8'h31,1,0, 0, 0,8'h20,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h77,8'h31,2,0, 0, 0,8'h20,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,32'h88,8'h31,3,1, 1, 0,8'h20,4));
        vecs.push_back(mk(0,0,8'h00,0, 1, 0,32'h00,8'h00,0,0, 1, 1,8'h31,4));

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("reset block_ready", 32'(bus.block_ready), 32'd1);
        checkOutput("reset instr_out", bus.instr_out, 32'd0);
        checkOutput("reset done_valid", 32'(bus.done_valid), 32'd0);
        checkOutput("reset done_block_id", 32'(bus.done_block_id), 32'd0);
        checkOutput("reset done_count", 32'(bus.done_count), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d instr_valid", i), 32'(bus.instr_valid), 32'(vecs[i].e_iv));
            if (vecs[i].e_iv) begin
                checkOutput($sformatf("v%0d instr_out", i), bus.instr_out, vecs[i].e_out);
                checkOutput($sformatf("v%0d instr_block_id", i), 32'(bus.instr_block_id), 32'(vecs[i].e_iid));
                checkOutput($sformatf("v%0d instr_slot", i), 32'(bus.instr_slot), 32'(vecs[i].e_slot));
                checkOutput($sformatf("v%0d instr_last", i), 32'(bus.instr_last), 32'(vecs[i].e_last));
            end
            checkOutput($sformatf("v%0d block_ready", i), 32'(bus.block_ready), 32'(vecs[i].e_br));
            checkOutput($sformatf("v%0d done_valid", i), 32'(bus.done_valid), 32'(vecs[i].e_dv));
            checkOutput($sformatf("v%0d done_block_id", i), 32'(bus.done_block_id), 32'(vecs[i].e_did));
            checkOutput($sformatf("v%0d done_count", i), 32'(bus.done_count), 32'(vecs[i].e_dcnt));
        end

        // Asynchronous reset in the middle of a block.
        applyStimulus(mk(0,1,8'h40,BA,1, 0,0,0,0,0, 0, 0,0,0));
        applyStimulus(mk(0,0,8'h00,0, 1, 0,0,0,0,0, 0, 0,0,0));
        checkOutput("arst pre instr_out", bus.instr_out, 32'h11);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("arst block_ready", 32'(bus.block_ready), 32'd1);
        checkOutput("arst instr_out", bus.instr_out, 32'd0);
        checkOutput("arst instr_slot", 32'(bus.instr_slot), 32'd0);
        checkOutput("arst done_block_id", 32'(bus.done_block_id), 32'd0);
        checkOutput("arst done_count", 32'(bus.done_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mk(0,0,8'h00,0, 1, 0,0,0,0,0, 0, 0,0,0));
        checkOutput("post-arst instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("post-arst done_valid", 32'(bus.done_valid), 32'd0);

        // With NOP skipping disabled every slot is issued, NOPs included.
        blkn = BN;
        @(negedge clk);
        busn.block_valid = 1'b1;
        busn.block_id_in = 8'h11;
        busn.block_in    = blkn;
        #1;
        checkOutput("noskip block_ready", 32'(busn.block_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            busn.block_valid = 1'b0;
            #1;
            checkOutput($sformatf("noskip%0d instr_valid", k), 32'(busn.instr_valid), 32'd1);
            checkOutput($sformatf("noskip%0d instr_out", k), busn.instr_out, blkn[k*32 +: 32]);
            checkOutput($sformatf("noskip%0d instr_slot", k), 32'(busn.instr_slot), 32'(k));
            checkOutput($sformatf("noskip%0d instr_last", k), 32'(busn.instr_last), 32'(k == 3));
        end
        @(negedge clk);
        #1;
        checkOutput("noskip done_valid", 32'(busn.done_valid), 32'd1);
        checkOutput("noskip done_block_id", 32'(busn.done_block_id), 32'h11);
        checkOutput("noskip done_count", 32'(busn.done_count), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
